// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: measurement sequencer for one TDC channel.
// Arms the channel, runs the coarse timestamp counter, strobes the thermometer
// sample registers on a stop hit, waits for the encoder to settle, merges the
// clamped fine bin with the latched coarse count and hands the result to
// readout, then observes a dead time before re-arming.
// Optional feature macro: LOST_HIT_CNT_EN adds o_lost_cnt, a saturating count
// of hits dropped while busy.
//
// Readout handshake: o_out_valid is high for the whole EMIT state; o_out_data,
// o_out_rollover and o_out_fine_err do not change while o_out_valid is high;
// a transfer happens in the cycle where o_out_valid && i_out_ready, and
// o_out_valid never falls without such a transfer (except on reset).
module tdc_meas_ctrl #(
  parameter int COARSE_W    = 24,
  parameter int FINE_W      = 8,
  parameter int FINE_MAX    = 200,
  parameter int ENC_LAT     = 2,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_arm,
  input  logic                         i_hit,
  output logic                         o_capture_en,
  input  logic [FINE_W-1:0]            i_fine_bin,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [COARSE_W+FINE_W-1:0]   o_out_data,
  output logic                         o_out_rollover,
  output logic                         o_out_fine_err,
  output logic                         o_busy,
`ifdef LOST_HIT_CNT_EN
  output logic [15:0]                  o_lost_cnt,
`endif
  output logic [2:0]                   o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SETTLE  = 3'd3,
    S_EMIT    = 3'd4,
    S_DEAD    = 3'd5
  } state_t;

  localparam logic [FINE_W-1:0] FINE_MAX_V  = FINE_W'(FINE_MAX);
  localparam logic [7:0]        SETTLE_LAST = 8'(ENC_LAT - 1);
  localparam logic [7:0]        DEAD_LAST   = 8'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic [COARSE_W-1:0]           r_coarse;
  logic [7:0]                    r_cnt;
  logic                          r_roll;
  logic                          r_out_roll;
  logic                          r_out_err;
  logic [COARSE_W+FINE_W-1:0]    r_data;
  logic                          w_hs;
  logic                          w_wrap;
  logic                          w_busy;
  logic                          w_fine_gt;
  logic [FINE_W-1:0]             w_fine_clamped;

  assign w_hs           = (r_state == S_EMIT) && i_out_ready;
  // A wrap is only a real wrap when the counter keeps running next cycle.
  assign w_wrap         = (r_state != S_IDLE) && (w_next != S_IDLE) && (&r_coarse);
  assign w_fine_gt      = i_fine_bin > FINE_MAX_V;
  assign w_fine_clamped = w_fine_gt ? FINE_MAX_V : i_fine_bin;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; arm low in ARMED wins over a simultaneous hit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_arm) w_next = S_ARMED;
      S_ARMED: begin
        if (!i_arm)     w_next = S_IDLE;
        else if (i_hit) w_next = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_SETTLE;
      S_SETTLE:  if (r_cnt == SETTLE_LAST) w_next = S_EMIT;
      S_EMIT: begin
        if (i_out_ready) begin
          if (DEAD_CYCLES == 0) w_next = i_arm ? S_ARMED : S_IDLE;
          else                  w_next = S_DEAD;
        end
      end
      S_DEAD:    if (r_cnt == DEAD_LAST) w_next = i_arm ? S_ARMED : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    o_capture_en = (r_state == S_CAPTURE);
    o_out_valid  = (r_state == S_EMIT);
    w_busy       = (r_state == S_CAPTURE) || (r_state == S_SETTLE) ||
                   (r_state == S_EMIT)    || (r_state == S_DEAD);
    o_busy       = w_busy;
    o_dbg_state  = r_state;
  end

  // Per-state cycle counter for SETTLE and DEAD; restarts on every transition.
  always_ff @(posedge i_clk) begin
    if (i_rst)                   r_cnt <= '0;
    else if (w_next != r_state)  r_cnt <= '0;
    else if (r_state == S_SETTLE || r_state == S_DEAD) r_cnt <= r_cnt + 8'd1;
  end

  // Coarse timestamp: zero in IDLE (and when heading there), free-running otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                    r_coarse <= '0;
    else if (r_state == S_IDLE || w_next == S_IDLE) r_coarse <= '0;
    else                                          r_coarse <= r_coarse + 1'b1;
  end

  // Sticky rollover flag; the emitting handshake clears it unless a wrap coincides.
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_roll <= 1'b0;
    else if (w_hs)   r_roll <= w_wrap;
    else if (w_wrap) r_roll <= 1'b1;
  end

  // Result assembly: coarse latched on the accepted hit, fine sampled in the last SETTLE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data     <= '0;
      r_out_err  <= 1'b0;
      r_out_roll <= 1'b0;
    end else begin
      if (r_state == S_ARMED && i_arm && i_hit)
        r_data[COARSE_W+FINE_W-1:FINE_W] <= r_coarse;
      if (r_state == S_SETTLE && r_cnt == SETTLE_LAST) begin
        r_data[FINE_W-1:0] <= w_fine_clamped;
        r_out_err          <= w_fine_gt;
        r_out_roll         <= r_roll | w_wrap;
      end
    end
  end

  assign o_out_data     = r_data;
  assign o_out_rollover = r_out_roll;
  assign o_out_fine_err = r_out_err;

`ifdef LOST_HIT_CNT_EN
  logic [15:0] r_lost;

  // Saturating count of hits that arrive while a measurement is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                       r_lost <= '0;
    else if (r_state == S_IDLE && w_next == S_ARMED) r_lost <= '0;
    else if (i_hit && w_busy && r_lost != 16'hFFFF)  r_lost <= r_lost + 16'd1;
  end

  assign o_lost_cnt = r_lost;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: directed bench for tdc_meas_ctrl. A default-parameter
// instance covers the vector table and multi-cycle corner sequences; a
// COARSE_W=4 instance covers coarse counter rollover.
module tb_tdc_meas_ctrl;

  localparam int CW = 24;
  localparam int FW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // main instance signals
  logic              arm = 1'b0, hit = 1'b0, rdy = 1'b0;
  logic [FW-1:0]     fb = '0;
  logic              cap, valid, roll, ferr, busy;
  logic [CW+FW-1:0]  data;
  logic [2:0]        dbg;
`ifdef LOST_HIT_CNT_EN
  logic [15:0]       lost;
`endif

  // 4-bit coarse instance signals
  logic              arm4 = 1'b0, hit4 = 1'b0, rdy4 = 1'b0;
  logic [FW-1:0]     fb4 = '0;
  logic              cap4, valid4, roll4, ferr4, busy4;
  logic [4+FW-1:0]   data4;
  logic [2:0]        dbg4;
`ifdef LOST_HIT_CNT_EN
  logic [15:0]       lost4;
`endif

  tdc_meas_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_hit(hit),
    .o_capture_en(cap), .i_fine_bin(fb), .o_out_valid(valid),
    .i_out_ready(rdy), .o_out_data(data), .o_out_rollover(roll),
    .o_out_fine_err(ferr), .o_busy(busy),
`ifdef LOST_HIT_CNT_EN
    .o_lost_cnt(lost),
`endif
    .o_dbg_state(dbg)
  );

  tdc_meas_ctrl #(.COARSE_W(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_arm(arm4), .i_hit(hit4),
    .o_capture_en(cap4), .i_fine_bin(fb4), .o_out_valid(valid4),
    .i_out_ready(rdy4), .o_out_data(data4), .o_out_rollover(roll4),
    .o_out_fine_err(ferr4), .o_busy(busy4),
`ifdef LOST_HIT_CNT_EN
    .o_lost_cnt(lost4),
`endif
    .o_dbg_state(dbg4)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Each step lands 1 ns after a rising edge: outputs of the new cycle are
  // stable and inputs written now are sampled at the following edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int            coarse;
    logic [FW-1:0] fine_in;
    logic [FW-1:0] exp_fine;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  // One full measurement from IDLE: arm, hit at the given coarse count,
  // immediate acceptance, then disarm and return to IDLE.
  task automatic measure(input vec_t v, input int idx);
    logic [CW+FW-1:0] e;
    e = {CW'(v.coarse), v.exp_fine};
    arm = 1'b1;
    step(1);                       // first ARMED cycle, coarse 0
    step(v.coarse);
    hit = 1'b1;                    // cycle t
    step(1);
    hit = 1'b0;                    // t+1
    check($sformatf("v%0d capture_en", idx), cap, 1);
    check($sformatf("v%0d busy", idx), busy, 1);
    fb = v.fine_in;
    step(2);                       // t+3
    check($sformatf("v%0d valid_early", idx), valid, 0);
    step(1);                       // t+4
    check($sformatf("v%0d valid", idx), valid, 1);
    check($sformatf("v%0d data", idx), data, e);
    check($sformatf("v%0d fine_err", idx), ferr, v.exp_err);
    check($sformatf("v%0d rollover", idx), roll, 0);
    rdy = 1'b1;
    step(1);                       // t+5, DEAD
    rdy = 1'b0;
    arm = 1'b0;
    check($sformatf("v%0d valid_after", idx), valid, 0);
    step(5);                       // t+10, IDLE
    check($sformatf("v%0d idle_busy", idx), busy, 0);
    fb = '0;
  endtask

  // ---------------- test body ----------------
  initial begin
    logic [CW+FW-1:0] held;
    int               nvalid;

    vecs[0] = '{coarse: 10, fine_in: 8'd37,  exp_fine: 8'd37,  exp_err: 1'b0};
    vecs[1] = '{coarse: 5,  fine_in: 8'd230, exp_fine: 8'd200, exp_err: 1'b1};
    vecs[2] = '{coarse: 7,  fine_in: 8'd200, exp_fine: 8'd200, exp_err: 1'b0};
    vecs[3] = '{coarse: 0,  fine_in: 8'd0,   exp_fine: 8'd0,   exp_err: 1'b0};
    vecs[4] = '{coarse: 3,  fine_in: 8'd255, exp_fine: 8'd200, exp_err: 1'b1};
    vecs[5] = '{coarse: 20, fine_in: 8'd201, exp_fine: 8'd200, exp_err: 1'b1};

    // reset state
    step(3);
    check("rst valid", valid, 0);
    check("rst capture_en", cap, 0);
    check("rst busy", busy, 0);
    check("rst data", data, 0);
    check("rst rollover", roll, 0);
    check("rst fine_err", ferr, 0);
    check("rst state", dbg, 0);
    rst = 1'b0;

    // table-driven measurements
    for (int i = 0; i < 6; i++) measure(vecs[i], i);

    // backpressure: ready low 20 cycles with 3 extra hits during EMIT
    arm = 1'b1;
    step(1);
    step(2);
    hit = 1'b1;
    fb  = 8'd50;
    step(1);
    hit = 1'b0;
    step(3);                       // t+4
    held = {24'd2, 8'd50};
    for (int i = 0; i < 20; i++) begin
      hit = (i == 2) || (i == 7) || (i == 12);
      check("stall valid", valid, 1);
      check("stall data", data, held);
      step(1);
    end
    hit = 1'b0;
    check("stall valid_end", valid, 1);
    rdy = 1'b1;
    step(1);
    rdy = 1'b0;
    arm = 1'b0;
    check("stall valid_after", valid, 0);
`ifdef LOST_HIT_CNT_EN
    check("stall lost_cnt", lost, 3);
`endif
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid) nvalid++;
      step(1);
    end
    check("stall single_result", nvalid, 0);

    // hit on the same cycle arm falls
    arm = 1'b1;
    step(1);
    step(3);
    arm = 1'b0;
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check("armfall capture_en", cap, 0);
    check("armfall state", dbg, 0);
    check("armfall busy", busy, 0);
`ifdef LOST_HIT_CNT_EN
    check("armfall lost_cnt", lost, 0);
`endif
    step(2);
    check("armfall capture_late", cap, 0);

    // arm dropped during SETTLE still emits, then IDLE after DEAD
    arm = 1'b1;
    step(1);
    step(4);
    hit = 1'b1;
    fb  = 8'd99;
    step(1);                       // t+1
    hit = 1'b0;
    step(1);                       // t+2, SETTLE
    arm = 1'b0;
    step(2);                       // t+4
    check("settledrop valid", valid, 1);
    check("settledrop data", data, {24'd4, 8'd99});
    rdy = 1'b1;
    step(1);                       // t+5
    rdy = 1'b0;
    step(3);                       // t+8, last DEAD
    check("settledrop dead_busy", busy, 1);
    step(1);                       // t+9
    check("settledrop state", dbg, 0);
    check("settledrop busy", busy, 0);

    // back-to-back with DEAD_CYCLES=4
    arm = 1'b1;
    step(1);
    step(1);
    hit = 1'b1;
    fb  = 8'd11;
    step(1);
    hit = 1'b0;
    step(3);                       // t+4
    check("b2b first valid", valid, 1);
    check("b2b first data", data, {24'd1, 8'd11});
    rdy = 1'b1;
    step(1);                       // t+5
    rdy = 1'b0;
    step(3);                       // t+8, last DEAD
    hit = 1'b1;
    step(1);                       // t+9, first ARMED
    check("b2b dead_hit capture", cap, 0);
    check("b2b armed state", dbg, 1);
    fb = 8'd22;
    step(1);                       // t+10
    hit = 1'b0;
    check("b2b armed_hit capture", cap, 1);
    step(3);                       // t+13
    check("b2b second valid", valid, 1);
    check("b2b second data", data, {24'd10, 8'd22});
`ifdef LOST_HIT_CNT_EN
    check("b2b lost_cnt", lost, 1);
`endif
    rdy = 1'b1;
    step(1);
    rdy = 1'b0;
    arm = 1'b0;
    step(6);

    // rollover with a 4-bit coarse counter
    arm4 = 1'b1;
    step(1);                       // coarse 0
    step(17);                      // coarse 1 after the wrap
    hit4 = 1'b1;
    fb4  = 8'd5;
    step(1);
    hit4 = 1'b0;
    step(3);
    check("w4 first valid", valid4, 1);
    check("w4 first data", data4, {4'd1, 8'd5});
    check("w4 first rollover", roll4, 1);
    rdy4 = 1'b1;
    step(1);
    rdy4 = 1'b0;
    step(4);                       // first ARMED, coarse 10
    hit4 = 1'b1;
    fb4  = 8'd6;
    step(1);
    hit4 = 1'b0;
    step(3);
    check("w4 second valid", valid4, 1);
    check("w4 second data", data4, {4'd10, 8'd6});
    check("w4 second rollover", roll4, 0);
    rdy4 = 1'b1;
    step(1);
    rdy4 = 1'b0;
    arm4 = 1'b0;
    step(6);

    // reset while a result is pending
    arm = 1'b1;
    step(1);
    step(1);
    hit = 1'b1;
    fb  = 8'd77;
    step(1);
    hit = 1'b0;
    step(3);
    check("midrst valid_before", valid, 1);
    rst = 1'b1;
    step(1);
    check("midrst valid", valid, 0);
    check("midrst data", data, 0);
    check("midrst state", dbg, 0);
    rst = 1'b0;
    arm = 1'b0;
    step(2);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for one TDC channel. Arms the channel and keeps the coarse timestamp counter. On a stop hit it strobes the thermometer sample registers, waits for the thermometer-to-binary encoder to settle, and merges its fine bin with the coarse count. The merged result goes to readout over a valid/ready handshake, followed by a dead time before re-arming.

Parameters:
COARSE_W, 24, coarse counter width (bits)
FINE_W, 8, fine bin width from encoder
FINE_MAX, 200, largest legal fine bin (delay-line length)
ENC_LAT, 2, cycles from capture_en to stable fine_bin (1..15)
DEAD_CYCLES, 4, dead-time cycles after a result is accepted (0..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
arm  in  1  level; channel enabled while high
hit  in  1  synchronized stop-event pulse, one cycle per event
capture_en  out  1  one-cycle strobe to thermometer sample registers
fine_bin  in  FINE_W  encoder output, valid ENC_LAT cycles after capture_en
out_valid  out  1  result valid
out_ready  in  1  readout accepts result
out_data  out  COARSE_W+FINE_W  {coarse, fine}
out_rollover  out  1  coarse counter wrapped since previous emitted result
out_fine_err  out  1  fine_bin exceeded FINE_MAX; fine field clamped
busy  out  1  high in CAPTURE, SETTLE, EMIT, DEAD

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active high. Reset puts the FSM in IDLE and clears every output and internal register to 0.
- States: IDLE, ARMED, CAPTURE, SETTLE, EMIT, DEAD.
- IDLE: coarse counter held at 0. arm=1 moves to ARMED next cycle; the counter starts from 0 that cycle.
- Coarse counter: increments by 1 every cycle outside IDLE. Wraps modulo 2^COARSE_W. Each wrap sets a sticky rollover flag. The flag clears on the handshake that emits it, unless a wrap occurs in that same cycle, in which case the flag stays set.
- ARMED: on hit=1 with arm=1, latch the coarse count of that cycle and go to CAPTURE. If hit and arm=0 occur in the same cycle, arm wins: the hit is ignored and the FSM goes to IDLE. arm=0 with no hit also goes to IDLE.
- CAPTURE: exactly 1 cycle, with capture_en=1. Then SETTLE.
- SETTLE: ENC_LAT cycles. fine_bin is sampled in the last SETTLE cycle. Then EMIT.
- Fine clamp: if the sampled fine_bin > FINE_MAX, the fine field is FINE_MAX and out_fine_err=1.
- EMIT: out_valid=1. out_data, out_rollover and out_fine_err are held stable until out_ready=1 (AXI-style; valid never drops without a handshake). On the handshake go to DEAD, or to ARMED/IDLE directly if DEAD_CYCLES=0. out_valid falls the next cycle.
- Latency: hit in cycle t gives capture_en in t+1 and out_valid first high in t+2+ENC_LAT (t+4 at defaults).
- DEAD: DEAD_CYCLES cycles. Then ARMED if arm=1, else IDLE.
- Hits while busy: any hit in CAPTURE, SETTLE, EMIT or DEAD is dropped with no effect on the current result.
- arm low mid-measurement: deasserting arm in any busy state does not abort. The current result completes and is emitted, then the FSM goes to IDLE after DEAD.
- Reset mid-operation: a pending result is discarded and out_valid drops the cycle after rst.

Optional Feature:
Macro LOST_HIT_CNT_EN.
- Defined: adds output lost_cnt (16 bits). It is a saturating count of hits dropped while busy, saturating at 16'hFFFF. It is cleared by rst and on IDLE->ARMED.
- Hits ignored because of simultaneous arm=0 are not counted.
- Not defined: no port and no counter logic.

Test Plan:
- Reset, arm=1, hit at coarse=10, fine_bin=37, out_ready=1 -> capture_en at hit+1; out_valid at hit+4; out_data={24'd10,8'd37}; rollover=0; fine_err=0.
- fine_bin=230 -> fine field 200, out_fine_err=1. Then fine_bin=200 -> fine field 200, out_fine_err=0.
- out_ready held low 20 cycles, plus 3 extra hits during EMIT -> out_valid and out_data stable throughout; exactly one result emitted; lost_cnt=3 with LOST_HIT_CNT_EN.
- COARSE_W=4, hit after the counter wraps past 15 -> out_rollover=1 on that result and 0 on the next result (no intervening wrap).
- Hit on the same cycle as arm falls -> no capture_en, FSM returns to IDLE, lost_cnt unchanged. arm dropped during SETTLE -> result still emitted, then IDLE.
- Back-to-back, DEAD_CYCLES=4: hit on the last DEAD cycle is dropped; hit on the first ARMED cycle produces a result.
